deque_host_driver: RTL

- Initiator for the dual-deque port: takes byte commands on a valid/ready channel and drives deque_select / end_select / push / pop / data_in toward the dual deque.
- Uses the four full/empty flags to refuse illegal operations, samples the deque's data_out for pops, and returns exactly one response per command on a valid/ready channel.
- Sits between a host interface (SPI/UART front end, test harness) and the dual deque.

---
 rtl/deque_host_driver_if.sv | 28 ++
 rtl/deque_host_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/deque_host_driver_if.sv
// Host-side command/response channel for the dual-deque host driver.
// master = host front end, slave = driver.
interface deque_host_driver_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic              cmd_deque;
    logic              cmd_end;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_deque, cmd_end, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_deque, cmd_end, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/deque_host_driver.sv
// Host driver for the dual deque: one command in flight, checks full/empty
// flags before strobing push/pop and returns exactly one response per command.
module deque_host_driver #(
    parameter int unsigned POP_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    deque_host_driver_if.slave  host,
    output logic                deque_select,
    output logic                end_select,
    output logic                push,
    output logic                pop,
    output logic [7:0]          data_in,
    input  logic                d0_empty,
    input  logic                d0_full,
    input  logic                d1_empty,
    input  logic                d1_full,
    input  logic [7:0]          data_out
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        OP_RSVD = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_STAT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    op_e                 op_q;
    logic                sel_q;
    logic                end_q;
    logic [DATA_W-1:0]   data_in_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                cmd_accept;
    logic                rsp_load;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_err_d;
    logic                sel_full;
    logic                sel_empty;
    logic                wait_done;

    assign sel_full  = sel_q ? d1_full  : d0_full;
    assign sel_empty = sel_q ? d1_empty : d0_empty;
    assign wait_done = (cnt_q == CNT_W'(POP_LATENCY));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_q == OP_POP && !sel_empty && POP_LATENCY != 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (host.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; strobes depend on the live flags of the selected deque
    always_comb begin
        host.cmd_ready = 1'b0;
        host.rsp_valid = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        cmd_accept     = 1'b0;
        rsp_load       = 1'b0;
        rsp_data_d     = '0;
        rsp_err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                host.cmd_ready = 1'b1;
                cmd_accept     = host.cmd_valid;
            end
            S_ISSUE: begin
                rsp_load = 1'b1;
                case (op_q)
                    OP_PUSH: begin
                        if (sel_full) begin
                            rsp_err_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (sel_empty) begin
                            rsp_err_d = 1'b1;
                        end else begin
                            pop = 1'b1;
                            if (POP_LATENCY == 0) begin
                                rsp_data_d = data_out;
                            end
                        end
                    end
                    OP_STAT: begin
                        rsp_data_d = {4'b0000, d1_full, d1_empty, d0_full, d0_empty};
                    end
                    default: begin
                        rsp_err_d = 1'b1;
                    end
                endcase
            end
            S_WAIT: begin
                if (wait_done) begin
                    rsp_load   = 1'b1;
                    rsp_data_d = data_out;
                end
            end
            S_RESP: begin
                host.rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Command capture, deque-side holding registers, response and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_RSVD;
            sel_q      <= 1'b0;
            end_q      <= 1'b0;
            data_in_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (cmd_accept) begin
                op_q      <= op_e'(host.cmd_op);
                sel_q     <= host.cmd_deque;
                end_q     <= host.cmd_end;
                data_in_q <= (op_e'(host.cmd_op) == OP_PUSH) ? host.cmd_data : '0;
            end
            if (rsp_load) begin
                rsp_data_q <= rsp_data_d;
                rsp_err_q  <= rsp_err_d;
            end
            if (state_q == S_ISSUE) begin
                cnt_q <= CNT_W'(1);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign deque_select  = sel_q;
    assign end_select    = end_q;
    assign data_in       = data_in_q;
    assign host.rsp_data = rsp_data_q;
    assign host.rsp_err  = rsp_err_q;

endmodule
